// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a word-wide RAM
// over req/gnt/rvalid; byte and half stores are read-modify-write.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        trunkMode,
    input  logic              sinSigno,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_store;
    logic [1:0]        r_mode;
    logic              r_uns;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_err;

    logic              w_accept;
    logic              w_bad;
    logic              w_word_st;
    logic [31:0]       w_ext;
    logic [31:0]       w_merged;
    logic              w_unused;

    assign w_unused  = ^addr[31:ADDR_W+2];
    assign w_accept  = op_valid & (MemRead | MemWrite) & (r_state == S_IDLE);
    assign w_word_st = MemWrite & (trunkMode == 2'b00);
    assign w_bad     = (MemRead & MemWrite)
                     | (trunkMode == 2'b11)
                     | ((trunkMode == 2'b01) & addr[0])
                     | ((trunkMode == 2'b00) & (addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_next = S_DONE;
                    end else if (w_word_st) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:    if (mem_gnt) w_next = S_RWAIT;
            S_RWAIT: if (mem_rvalid) w_next = r_store ? S_WR : S_DONE;
            S_WR:    if (mem_gnt) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        w_ext    = mem_rdata;
        w_merged = mem_rdata;
        unique case (r_mode)
            2'b01: begin
                w_ext = {16'b0, mem_rdata[{r_off[1], 4'b0000} +: 16]};
                if (!r_uns) w_ext[31:16] = {16{w_ext[15]}};
                w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
            end
            2'b10: begin
                w_ext = {24'b0, mem_rdata[{r_off, 3'b000} +: 8]};
                if (!r_uns) w_ext[31:8] = {24{w_ext[7]}};
                w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_store     <= 1'b0;
            r_mode      <= 2'b00;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= 16'b0;
            r_rdata     <= 32'b0;
            r_mem_wdata <= 32'b0;
            r_mem_addr  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_store     <= MemWrite;
                r_mode      <= trunkMode;
                r_uns       <= sinSigno;
                r_off       <= addr[1:0];
                r_wdata     <= wdata[15:0];
                r_mem_addr  <= addr[ADDR_W+1:2];
                r_mem_wdata <= wdata;
                if (w_bad) r_err <= 1'b1;
            end
            if ((r_state == S_RWAIT) && mem_rvalid) begin
                if (r_store) begin
                    r_mem_wdata <= w_merged;
                end else begin
                    r_rdata <= w_ext;
                    r_err   <= 1'b0;
                end
            end
            if ((r_state == S_WR) && mem_gnt) r_err <= 1'b0;
        end
    end

    assign mem_req   = (r_state == S_RD) | (r_state == S_WR);
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign stall     = w_accept | (r_state == S_RD) | (r_state == S_RWAIT)
                     | (r_state == S_WR);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine; the consumer end of the decoder's memory control signals (MemRead, MemWrite, trunkMode, sinSigno).
- Takes one memory op from the EX/MEM register and drives a word-wide RAM through a request/grant/response handshake.
- Byte and half stores are done as read-modify-write. Load data is returned lane-extracted and sign- or zero-extended.
- Holds the pipeline via stall until the op completes.

Parameters:
- ADDR_W, 10, word-address width of the RAM port; byte address bits [ADDR_W+1:2] form the word address.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op_valid  in  1  EX/MEM holds a candidate op
- MemRead  in  1  load op
- MemWrite  in  1  store op
- trunkMode  in  2  00 word, 01 half, 10 byte, 11 reserved
- sinSigno  in  1  zero-extend loads when 1
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rt value, low bits significant)
- stall  out  1  freeze upstream pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid when done
- err  out  1  with done: misaligned or illegal op, no memory side effects
- mem_req  out  1  memory request, held until granted
- mem_we  out  1  write when 1
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write word
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; never in the same cycle as its grant
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, asserted): state IDLE; stall, done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
- Accept: op_valid & IDLE & (MemRead|MemWrite). Op fields are latched on the accept edge.
- op_valid with neither MemRead nor MemWrite: ignored; no stall, no done.
- stall = (IDLE & accept condition) | (state not in {IDLE, DONE}). stall is 0 in DONE.
- States: IDLE, RD, RWAIT, WR, DONE.
- Error check at accept: MemRead&MemWrite; trunkMode=11; half with addr[0]=1; word with addr[1:0]!=0. On error go IDLE->DONE with err=1 and no mem_req.
- Word store: IDLE->WR.
- Load and sub-word store: IDLE->RD.
- RD: mem_req=1, mem_we=0. On mem_gnt go to RWAIT.
- RWAIT: on mem_rvalid, a load captures the extracted result and goes to DONE; a sub-word store merges into the captured word and goes to WR.
- WR: mem_req=1, mem_we=1, mem_wdata = merged word (sub-word store) or wdata (word store). On mem_gnt go to DONE.
- DONE: done=1 for one cycle, then IDLE. A new op may be accepted in the cycle after DONE.
- Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
- Load extract: word passes through. Half = rd[16*addr[1]+:16]. Byte = rd[8*addr[1:0]+:8]. Extend with the top bit of the field when sinSigno=0, zeros when sinSigno=1. A word load ignores sinSigno.
- Merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]; all other bytes are kept from the read word.
- Minimum latency (accept cycle = T, grant same cycle as request): word store done at T+2; load done at T+3; sub-word store done at T+4; error done at T+1. Each extra grant or response wait cycle adds one cycle.
- mem_rvalid outside RWAIT is ignored.
- mem_req stays high across denied cycles with address and data stable.
- Reset mid-operation returns to IDLE immediately and drops mem_req. A late response after reset is ignored.
- rdata and err hold their value until the next done.

Test Plan:
- Load word, addr=0x10, RAM[4]=0xDEADBEEF, grant immediate, rvalid 1 cycle after grant -> done at T+3, rdata=0xDEADBEEF, err=0, stall high T..T+2.
- Load byte, addr=0x13, RAM[4]=0x80FF1234: sinSigno=0 -> rdata=0xFFFFFF80; sinSigno=1 -> 0x00000080. Load half at addr=0x12 with sinSigno=0 -> 0xFFFF80FF.
- Store byte, addr=0x21, wdata=0x000000AB, RAM[8]=0x11223344 -> read then write mem_addr=8, mem_wdata=0x1122AB44; done at T+4.
- Store half, addr=0x31 -> err=1 and done at T+1, no mem_req ever asserted. Same check with MemRead=MemWrite=1, and with trunkMode=11.
- Word store with mem_gnt held low 3 cycles -> mem_req, mem_addr and mem_wdata stable throughout; done at T+5; stall=0 in the done cycle.
- reset_n pulsed low during RWAIT of a load -> mem_req=0 and stall=0 immediately; the subsequent mem_rvalid is ignored; the next op completes correctly.
